// File: rtl/lsu_ctrl.sv
// Load/store unit controller: bridges the MEM stage to a single-outstanding data bus.
// Optional response watchdog is compiled in when LSU_TIMEOUT_EN is defined.

module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        store_hand_suc,
  output logic        load_hand_suc,
  output logic [31:0] mem_ld_data,
  output logic        mem_ld_misal,
  output logic        mem_st_misal,
  output logic        mem_bus_err,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rsp_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t      state_q, state_d;

  logic [29:0] word_addr_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] ld_data_q;

  logic        access;
  logic        aligned;
  logic        start;
  logic        misal;
  logic        done_ok;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_shift;
  logic [31:0] ld_fmt;
  logic        ld_capture;
  logic        to_err;
  logic        timeout;

  always_comb begin
    aligned = 1'b1;
    case (mem_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~mem_addr[0];
      default: aligned = (mem_addr[1:0] == 2'b00);
    endcase
  end

  assign access = mem_valid & (mem_we | mem_re);
  assign start  = (state_q == IDLE) & access & aligned & ~pipe_flush;
  // Misaligned accesses complete combinationally in IDLE; held off while reset is asserted.
  assign misal  = rst_n & (state_q == IDLE) & access & ~aligned & ~pipe_flush;

  always_comb begin
    st_wdata = mem_wdata;
    st_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{mem_wdata[7:0]}};
        st_wstrb = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{mem_wdata[15:0]}};
        st_wstrb = 4'b0011 << mem_addr[1:0];
      end
      default: ;
    endcase
    if (!mem_we) begin
      st_wdata = '0;
      st_wstrb = '0;
    end
  end

  always_comb begin
    ld_shift = dbus_rsp_rdata >> {addr_lo_q, 3'b000};
    ld_fmt   = dbus_rsp_rdata;
    case (funct3_q)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_fmt = {24'b0, ld_shift[7:0]};
      3'b101:  ld_fmt = {16'b0, ld_shift[15:0]};
      default: ld_fmt = dbus_rsp_rdata;
    endcase
  end

  // A flush after the bus accepted the request leaves one response in flight to swallow.
  always_comb begin
    state_d    = state_q;
    ld_capture = 1'b0;
    to_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        if (dbus_req_ready)  state_d = pipe_flush ? DRAIN : WAIT;
        else if (pipe_flush) state_d = IDLE;
      end
      WAIT: begin
        if (pipe_flush) begin
          state_d = dbus_rsp_valid ? IDLE : DRAIN;
        end else if (dbus_rsp_valid) begin
          state_d    = DONE;
          ld_capture = 1'b1;
        end else if (timeout) begin
          state_d = DONE;
          to_err  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (dbus_rsp_valid || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ld_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        word_addr_q <= mem_addr[31:2];
        addr_lo_q   <= mem_addr[1:0];
        funct3_q    <= mem_funct3;
        we_q        <= mem_we;
        wdata_q     <= st_wdata;
        wstrb_q     <= st_wstrb;
      end
      if (ld_capture)  ld_data_q <= ld_fmt;
      else if (to_err) ld_data_q <= '0;
    end
  end

  assign done_ok = (state_q == DONE) & ~pipe_flush;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wdog_q;
  logic          bus_err_q;

  // Counter restarts on every state change, so it measures time spent in the current WAIT/DRAIN.
  assign timeout = ((state_q == WAIT) | (state_q == DRAIN)) &
                   (wdog_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_d != state_q)
        wdog_q <= '0;
      else if ((state_q == WAIT) || (state_q == DRAIN))
        wdog_q <= wdog_q + CW'(1);
      if (start)       bus_err_q <= 1'b0;
      else if (to_err) bus_err_q <= 1'b1;
    end
  end

  assign mem_bus_err = done_ok & bus_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
  assign mem_bus_err        = 1'b0;
`endif

  assign store_hand_suc = (done_ok & we_q)  | (misal & mem_we);
  assign load_hand_suc  = (done_ok & ~we_q) | (misal & mem_re);
  assign mem_st_misal   = misal & mem_we;
  assign mem_ld_misal   = misal & mem_re;
  assign mem_ld_data    = ld_data_q;

  assign dbus_req_valid = (state_q == REQ);
  assign dbus_we        = dbus_req_valid & we_q;
  assign dbus_addr      = dbus_req_valid ? {word_addr_q, 2'b00} : '0;
  assign dbus_wdata     = dbus_req_valid ? wdata_q : '0;
  assign dbus_wstrb     = dbus_req_valid ? wstrb_q : '0;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: response watchdog limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pipe_flush  input  1  pipeline flush, active-high.
REQ-005 mem_valid  input  1  MEM stage holds a valid instruction.
REQ-006 mem_we / mem_re  input  1 each  instruction is a store / a load (never both).
REQ-007 mem_funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 mem_addr / mem_wdata  input  32 each  effective address / store data.
REQ-009 store_hand_suc / load_hand_suc  output  1 each  access complete; MEM stage may advance.
REQ-010 mem_ld_data  output  32  aligned, extended load result.
REQ-011 mem_ld_misal / mem_st_misal / mem_bus_err  output  1 each  exception flags, valid while hand_suc is high.
REQ-012 dbus_req_valid  output  1; dbus_req_ready  input  1; dbus_we  output  1; dbus_addr  output  32 (word-aligned); dbus_wdata  output  32; dbus_wstrb  output  4.
REQ-013 dbus_rsp_valid  input  1; dbus_rsp_rdata  input  32.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-015 Access start: IDLE, mem_valid & (mem_we|mem_re), address aligned -> latch addr[1:0], funct3, we, and formatted wdata/wstrb; go to REQ.
REQ-016 Alignment: H requires addr[0]=0; W requires addr[1:0]=00; B is always aligned.
REQ-017 Misaligned access SHALL issue no bus request; in IDLE the matching hand_suc and misal flag SHALL be asserted combinationally the same cycle; state stays IDLE.
REQ-018 REQ: dbus_req_valid=1 with address/data/strobe held stable until dbus_req_ready; on ready -> WAIT.
REQ-019 WAIT: on dbus_rsp_valid, register load data, go to DONE.
REQ-020 DONE lasts exactly one cycle: store_hand_suc (we) or load_hand_suc (re) =1; then IDLE.
REQ-021 Minimum latency from start to hand_suc with zero-wait bus: 3 cycles (REQ, WAIT, DONE).
REQ-022 Store format: SB replicates byte x4, wstrb=0001<<addr[1:0]; SH replicates half x2, wstrb=0011<<addr[1:0]; SW wstrb=1111.
REQ-023 Load format: select byte/half by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend to 32 bits.
REQ-024 Flush in REQ (not yet accepted) -> IDLE, dbus_req_valid drops next cycle, no hand_suc.
REQ-025 Flush in REQ coincident with dbus_req_ready, or flush in WAIT -> DRAIN; DRAIN swallows one response then -> IDLE; no hand_suc.
REQ-026 Flush in DONE SHALL suppress hand_suc that cycle; -> IDLE.
REQ-027 Flush in IDLE suppresses start and misaligned hand_suc.
REQ-028 No new access SHALL start in DRAIN.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; all outputs 0; mem_ld_data=0; latched fields=0; watchdog counter=0.
REQ-030 Reset mid-transaction abandons it; any later stray response is ignored in IDLE.

Configuration
REQ-031 Macro LSU_TIMEOUT_EN: when defined, a counter runs in WAIT/DRAIN; reaching TIMEOUT_CYCLES in WAIT -> DONE with mem_bus_err=1 and mem_ld_data=0; reaching it in DRAIN -> IDLE.
REQ-032 Without LSU_TIMEOUT_EN: no counter; mem_bus_err tied 0; WAIT/DRAIN wait indefinitely.

Verification
REQ-033 LB addr 0x1003, rdata 0x80FF_FF7F, zero-wait bus -> load_hand_suc 3 cycles after start, mem_ld_data=0xFFFF_FF80.
REQ-034 SH addr 0x2002, wdata 0x0000_BEEF -> dbus_addr=0x2000, wdata=0xBEEF_BEEF, wstrb=1100, store_hand_suc pulses one cycle.
REQ-035 LW addr 0x3001 -> no dbus_req_valid, mem_ld_misal=1 and load_hand_suc=1 same cycle.
REQ-036 LW issued, ready accepted, flush in WAIT, response 2 cycles later -> no hand_suc; next access starts only after the response is drained.
REQ-037 dbus_req_ready low 5 cycles -> req_valid/addr/wdata/wstrb stable all 5 cycles; hand_suc only after completion.
REQ-038 With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> load_hand_suc and mem_bus_err=1 after 16 WAIT cycles.
